// File: rtl/pwm_density_decoder.sv
// -----------------------------------------------------------------------------
// pwm_density_decoder
//
// Recovers the WIDTH-bit level carried by a first-order sigma-delta LED stream.
// The encoder adds the level to a WIDTH-bit accumulator every clock and drives
// the carry as the output bit. Over any 2**WIDTH consecutive steady-state
// cycles it therefore emits exactly `level` active bits. Counting the active
// samples over a fixed 2**WIDTH-cycle window gives the level back exactly.
//
// The input is asynchronous, for example looped back from pwm_led or driven
// from a second board. It passes through a SYNC_STAGES-deep synchronizer
// before it is counted.
//
// Ports
//   clk_50mhz   in   1      system clock
//   rst_n       in   1      asynchronous active-low reset (async assert,
//                           release synchronized internally)
//   pwm_in      in   1      asynchronous density-modulated input
//   enable      in   1      1 = measure; 0 = idle, partial window discarded
//   duty        out  WIDTH  last measured level, held between windows
//   duty_valid  out  1      one-cycle pulse when duty is updated
//   saturated   out  1      last window counted 2**WIDTH actives (duty clamped)
//   locked      out  1      STABLE_COUNT+1 consecutive identical results
//
// Parameters
//   WIDTH         level width; window length = 2**WIDTH clock cycles
//   ACTIVE_LOW    1: pwm_in low is an active sample; 0: high is active
//   SYNC_STAGES   input synchronizer depth (>= 2)
//   STABLE_COUNT  matching windows after the first that are needed for locked
//                 (>= 1)
//
// Timing
//   - One result every 2**WIDTH cycles.
//   - The first duty_valid comes 2*2**WIDTH cycles after ACQUIRE is entered:
//     one window flushes the synchronizer and encoder phase, one measures.
//   - Every output is a flop. There is no combinational path from pwm_in or
//     enable to any output.
// -----------------------------------------------------------------------------
module pwm_density_decoder #(
  parameter int WIDTH        = 7,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 3
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [WIDTH-1:0] duty,
  output logic             duty_valid,
  output logic             saturated,
  output logic             locked
);

  localparam int SCW = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);

  localparam logic [WIDTH-1:0]       WIN_LAST   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]         FULL       = {1'b1, {WIDTH{1'b0}}};
  localparam logic [SCW-1:0]         STABLE_MAX = SCW'(STABLE_COUNT);
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE  = {SYNC_STAGES{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_MEASURE
  } state_t;

  // A full window of actives reads as 2**WIDTH. That does not fit in the
  // output, so it is clamped to the largest level and flagged separately.
  function automatic logic [WIDTH-1:0] clamp_level(input logic [WIDTH:0] cnt);
    return (cnt == FULL) ? {WIDTH{1'b1}} : cnt[WIDTH-1:0];
  endfunction

  function automatic logic is_full(input logic [WIDTH:0] cnt);
    return (cnt == FULL);
  endfunction

  // Match counter that sticks at its ceiling.
  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
    return (v == STABLE_MAX) ? v : v + SCW'(1);
  endfunction

  logic [1:0]             rst_sync;
  logic                   rst_int_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       win_cnt;
  logic [WIDTH:0]         hi_cnt;
  logic                   win_end;
  logic                   acq_done;
  logic                   result_ld;
  logic [WIDTH:0]         final_cnt;
  logic [WIDTH-1:0]       result;

  logic                   first_pending;
  logic [WIDTH-1:0]       prev;
  logic [SCW-1:0]         stable_cnt;
  logic [SCW-1:0]         stable_nxt;

  // ---- reset release synchronizer ----
  // Reset asserts immediately. It is released only on a clock edge, so no
  // flop sees rst_n rise close to the clock.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  // ---- input synchronizer ----
  // The chain resets to the inactive pin level, so that reset is not seen as
  // a burst of active samples.
  always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_q <= SYNC_IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  // The active sample is 1 regardless of the pin polarity. The synchronizer
  // latency is not compensated. It only shifts which input samples fall in a
  // window, and any window of a steady stream holds the same count.
  assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // ---- control decode ----
  assign win_end   = (win_cnt == WIN_LAST);
  assign acq_done  = enable && (state == ST_ACQUIRE) && win_end;
  assign result_ld = enable && (state == ST_MEASURE) && win_end;

  // The final count includes the sample of the window-end cycle itself.
  // hi_cnt restarts on the next cycle, so no sample is lost between windows.
  assign final_cnt = hi_cnt + {{WIDTH{1'b0}}, sample};
  assign result    = clamp_level(final_cnt);

  // ---- FSM state register ----
  always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: state_nxt = win_end ? ST_MEASURE : ST_ACQUIRE;
        ST_MEASURE: state_nxt = ST_MEASURE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- window counters ----
  // ACQUIRE only steps win_cnt. Its window is thrown away, so hi_cnt stays
  // at 0 and MEASURE starts from a clean count.
  always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!enable || (state == ST_IDLE)) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
    end else if (state == ST_ACQUIRE) begin
      win_cnt <= win_cnt + WIDTH'(1);
      hi_cnt  <= '0;
    end else begin
      win_cnt <= win_cnt + WIDTH'(1);
      hi_cnt  <= win_end ? '0 : final_cnt;
    end
  end

  // ---- result registers ----
  // duty and saturated hold their last value while disabled. Only reset
  // clears them.
  always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      duty       <= '0;
      duty_valid <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      duty_valid <= result_ld;
      if (result_ld) begin
        duty      <= result;
        saturated <= is_full(final_cnt);
      end
    end
  end

  // ---- lock tracking ----
  // The comparison uses the clamped value. A stream that is stuck active
  // therefore locks like any other constant level.
  always_comb begin
    stable_nxt = stable_cnt;
    if (first_pending) begin
      stable_nxt = '0;
    end else if (result == prev) begin
      stable_nxt = sat_inc(stable_cnt);
    end else begin
      stable_nxt = '0;
    end
  end

  // The first result of a measurement run only seeds prev. It cannot be
  // compared, because prev may still hold a value from before the pause.
  always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      first_pending <= 1'b0;
      prev          <= '0;
      stable_cnt    <= '0;
      locked        <= 1'b0;
    end else if (!enable) begin
      first_pending <= 1'b0;
      stable_cnt    <= '0;
      locked        <= 1'b0;
    end else if (acq_done) begin
      first_pending <= 1'b1;
    end else if (result_ld) begin
      first_pending <= 1'b0;
      prev          <= result;
      stable_cnt    <= stable_nxt;
      locked        <= (stable_nxt == STABLE_MAX);
    end
  end

endmodule

// File: tb/tb_pwm_density_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_density_decoder
//
// Drives the decoder from a bit-true sigma-delta encoder, or from a pin held
// at a fixed level. Every cycle it compares duty_valid, duty, saturated and
// locked with a reference that works from the driven pin history:
//   - A result appears every 128 cycles, starting 256 cycles after entry
//     into ACQUIRE.
//   - Each result is the number of active pin samples in the 128-cycle
//     window that ends SYNC+1 cycles before the result appears.
//   - locked is high when the last four results of the current run are equal.
// -----------------------------------------------------------------------------
module tb_pwm_density_decoder;

  localparam int WIDTH  = 7;
  localparam int WIN    = 1 << WIDTH;
  localparam int SYNC   = 2;
  localparam int MAXCYC = 16000;

  logic             clk_50mhz = 1'b0;
  logic             rst_n     = 1'b1;
  logic             pwm_in    = 1'b1;
  logic             enable    = 1'b0;
  logic [WIDTH-1:0] duty;
  logic             duty_valid;
  logic             saturated;
  logic             locked;

  always #10 clk_50mhz = ~clk_50mhz;

  pwm_density_decoder #(
    .WIDTH       (WIDTH),
    .ACTIVE_LOW  (1'b1),
    .SYNC_STAGES (SYNC),
    .STABLE_COUNT(3)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .enable    (enable),
    .duty      (duty),
    .duty_valid(duty_valid),
    .saturated (saturated),
    .locked    (locked)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit hist [0:MAXCYC];

  // stimulus state; mode 0 = encoder, 1 = pin stuck active, 2 = pin idle
  int enc_acc;
  int level;
  int mode;
  bit en_drv;
  bit prev_en;
  bit in_reset;

  // reference state
  int acq_start;
  int exp_duty;
  bit exp_sat;
  int run_q[$];

  // observations of the DUT within the current segment
  int seg_pulses;
  int seg_lock_idx;
  int seg_first_lock;
  int seg_first_sat;
  int obs_first_dly;
  int gap_bad;
  int last_pulse;
  int odd_vals;
  bit track_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int win_count(input int t);
    int c = 0;
    for (int k = t - SYNC - WIN; k <= t - 1 - SYNC; k++) c += int'(hist[k]);
    return c;
  endfunction

  function automatic bit model_locked();
    int n = run_q.size();
    if (n < 4) return 1'b0;
    return (run_q[n-1] == run_q[n-2]) && (run_q[n-2] == run_q[n-3]) &&
           (run_q[n-3] == run_q[n-4]);
  endfunction

  task automatic mark();
    seg_pulses     = 0;
    seg_lock_idx   = 0;
    seg_first_lock = -1;
    seg_first_sat  = -1;
    obs_first_dly  = -1;
    gap_bad        = 0;
    last_pulse     = 0;
  endtask

  // Each call advances one clock. It checks the outputs of the new cycle and
  // then drives the inputs for that cycle.
  task automatic step();
    bit exp_dv;
    bit active;
    int cnt;
    int sum;
    @(posedge clk_50mhz);
    #1;
    cyc++;
    if (cyc >= MAXCYC) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXCYC);
      $fatal(1);
    end

    exp_dv = !in_reset && (acq_start >= 0) && (cyc - acq_start >= 2 * WIN) &&
             (((cyc - acq_start) % WIN) == 0);
    if (exp_dv) begin
      cnt      = win_count(cyc);
      exp_duty = (cnt >= WIN) ? WIN - 1 : cnt;
      exp_sat  = (cnt == WIN);
      run_q.push_back(exp_duty);
    end
    chk("duty_valid", duty_valid, exp_dv);
    chk("duty", duty, exp_duty);
    chk("saturated", saturated, exp_sat);
    chk("locked", locked, model_locked());

    if (duty_valid === 1'b1) begin
      seg_pulses++;
      if (seg_pulses == 1) begin
        obs_first_dly  = cyc - acq_start;
        seg_first_lock = int'(locked);
        seg_first_sat  = int'(saturated);
      end else if (cyc - last_pulse != WIN) begin
        gap_bad++;
      end
      last_pulse = cyc;
      if (locked === 1'b1 && seg_lock_idx == 0) seg_lock_idx = seg_pulses;
      if (track_step && duty != 7'd37 && duty != 7'd90) odd_vals++;
    end

    case (mode)
      0: begin
        sum     = enc_acc + level;
        active  = (sum >= WIN);
        enc_acc = sum % WIN;
      end
      1:       active = 1'b1;
      default: active = 1'b0;
    endcase
    pwm_in    = active ? 1'b0 : 1'b1;
    hist[cyc] = active;
    enable    = en_drv;
    if (en_drv && !prev_en) begin
      acq_start = cyc + 1;
      run_q.delete();
    end else if (!en_drv) begin
      acq_start = -1;
      run_q.delete();
    end
    prev_en = en_drv;
  endtask

  // Steps until the cycle about to be driven sits at window position pos.
  task automatic run_to_pos(input int pos);
    for (int i = 0; i < WIN; i++) begin
      if (((cyc + 1 - acq_start) % WIN) == pos) break;
      step();
    end
  endtask

  initial begin
    enc_acc = 0; level = 0; mode = 2; en_drv = 0; prev_en = 0; in_reset = 1;
    acq_start = -1; exp_duty = 0; exp_sat = 0; track_step = 0; odd_vals = 0;
    mark();

    // reset state
    #2 rst_n = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    in_reset = 0;
    repeat (6) step();

    // T2: level 37, random encoder phase
    mode = 0; level = 37; enc_acc = int'($urandom_range(0, WIN - 1));
    repeat ($urandom_range(0, 20)) step();
    mark();
    en_drv = 1;
    repeat (8 * WIN + 2) step();
    chk("t2_first_pulse_delay", obs_first_dly, 2 * WIN);
    chk("t2_pulse_gap_errors", gap_bad, 0);
    chk("t2_lock_on_pulse", seg_lock_idx, 4);
    chk("t2_duty", duty, 37);

    // T5: step 37 -> 90 in mid-window
    run_to_pos(int'($urandom_range(20, 100)));
    level = 90; track_step = 1; odd_vals = 0;
    mark();
    repeat (6 * WIN) step();
    track_step = 0;
    chk("t5_intermediate_le1", (odd_vals <= 1), 1);
    chk("t5_unlock_first", seg_first_lock, 0);
    chk("t5_relock_pulse", seg_lock_idx, 5);
    chk("t5_duty", duty, 90);

    // T6: drop enable at window position 60, then re-enable
    run_to_pos(60);
    en_drv = 0;
    step();
    mark();
    repeat (300) step();
    chk("t6_no_pulse", seg_pulses, 0);
    chk("t6_duty_hold", duty, 90);
    chk("t6_unlocked", locked, 0);
    level = 37;
    mark();
    en_drv = 1;
    repeat (6 * WIN + 2) step();
    chk("t6_first_pulse_delay", obs_first_dly, 2 * WIN);
    chk("t6_lock_on_pulse", seg_lock_idx, 4);
    chk("t6_duty", duty, 37);

    // enable dropped on the window-end cycle discards that window
    run_to_pos(WIN - 1);
    en_drv = 0;
    step();
    mark();
    repeat (10) step();
    chk("winend_no_pulse", seg_pulses, 0);
    chk("winend_duty_hold", duty, 37);

    // T3: level 0 (pin held inactive), then level 127
    mode = 2;
    repeat (2) step();
    mark();
    en_drv = 1;
    repeat (4 * WIN + 2) step();
    chk("t3_first_pulse_delay", obs_first_dly, 2 * WIN);
    chk("t3_zero_duty", duty, 0);
    chk("t3_zero_sat", saturated, 0);
    mode = 0; level = WIN - 1;
    repeat (3 * WIN + 2) step();
    chk("t3_max_duty", duty, WIN - 1);
    chk("t3_max_sat", saturated, 0);

    // T4: pin stuck active, then released to level 5
    mode = 1;
    repeat (6 * WIN) step();
    chk("t4_stuck_duty", duty, WIN - 1);
    chk("t4_stuck_sat", saturated, 1);
    chk("t4_stuck_locked", locked, 1);
    run_to_pos(64);
    mode = 0; level = 5;
    mark();
    repeat (3 * WIN) step();
    chk("t4_sat_clear_next", seg_first_sat, 0);
    chk("t4_duty", duty, 5);

    // T1: asynchronous reset at window position 60 of MEASURE
    for (int i = 0; i < WIN; i++) begin
      if (((cyc - acq_start) % WIN) == 60) break;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("t1_duty_async", duty, 0);
    chk("t1_valid_async", duty_valid, 0);
    chk("t1_sat_async", saturated, 0);
    chk("t1_locked_async", locked, 0);
    in_reset = 1; en_drv = 0; enable = 1'b0; prev_en = 0; acq_start = -1;
    exp_duty = 0; exp_sat = 0; run_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    in_reset = 0;
    mark();
    repeat (300) step();
    chk("t1_no_pulse_after_release", seg_pulses, 0);
    mark();
    en_drv = 1;
    repeat (4 * WIN + 2) step();
    chk("t1_first_pulse_delay", obs_first_dly, 2 * WIN);
    chk("t1_duty", duty, 5);

    // random levels and random enable toggling
    for (int i = 0; i < 3; i++) begin
      level = int'($urandom_range(1, WIN - 2));
      repeat (3 * WIN) step();
    end
    for (int i = 0; i < 6; i++) begin
      en_drv = ~en_drv;
      if (en_drv) level = int'($urandom_range(0, WIN - 1));
      repeat ($urandom_range(40, 300)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
